regfile_scoreboard: RTL and testbench

- Architectural register file (x0..x31) with a per-register pending-write counter (wcnt) scoreboard.
- The decode stage uses it to sequence operand reads: it polls rs1/rs2 until their wcnt is 0, then reserves rd.
- The writeback stage retires reservations and writes results.
- Also provides a global flush and sticky error reporting for counter overflow.

---
 rtl/regfile_scoreboard.sv | 144 ++++++++++++++
 tb/tb_regfile_scoreboard.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// Module   : regfile_scoreboard
// Purpose  : Architectural register file (x0..x31) with a per-register
//            pending-write counter scoreboard. Decode polls rs1/rs2 until
//            their pending count is zero and then reserves rd; writeback
//            retires reservations and writes results. A global flush clears
//            all pending counts, and a sticky error flags a reservation made
//            at a saturated count.
// Ports    : clk            - clock, rising edge
//            rst            - asynchronous active-low reset
//            rdy            - global ready, 0 freezes all state
//            read_rs1/rs2   - read requests; rsX_id selects the register
//            rs1/rs2_val_raw- registered read data (post-update value)
//            rs1/rs2_wcnt   - registered pending count, zero-extended
//            write_rd_wcnt  - reserve rd_id (increment its count)
//            wb_en          - writeback wb_val to wb_id (decrement its count)
//            flush          - clear all pending counts
//            busy_any       - registered, any pending count nonzero
//            ovf_err        - sticky reservation-at-saturation error
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_scoreboard #(
  parameter int REG_CNT     = 32,
  parameter int LOG_REG_CNT = 5,
  parameter int WCNT_W      = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   read_rs1,
  input  logic [LOG_REG_CNT-1:0] rs1_id,
  output logic [31:0]            rs1_val_raw,
  output logic [31:0]            rs1_wcnt,
  input  logic                   read_rs2,
  input  logic [LOG_REG_CNT-1:0] rs2_id,
  output logic [31:0]            rs2_val_raw,
  output logic [31:0]            rs2_wcnt,
  input  logic                   write_rd_wcnt,
  input  logic [LOG_REG_CNT-1:0] rd_id,
  input  logic                   wb_en,
  input  logic [LOG_REG_CNT-1:0] wb_id,
  input  logic [31:0]            wb_val,
  input  logic                   flush,
  output logic                   busy_any,
  output logic                   ovf_err
);

  localparam logic [WCNT_W-1:0] WCNT_MAX = '1;

  logic [31:0]       regs_q [REG_CNT];
  logic [31:0]       regs_d [REG_CNT];
  logic [WCNT_W-1:0] wcnt_q [REG_CNT];
  logic [WCNT_W-1:0] wcnt_d [REG_CNT];

  logic              busy_q, busy_d;
  logic              ovf_q, ovf_d;
  logic [31:0]       rs1_val_q, rs2_val_q;
  logic [WCNT_W-1:0] rs1_cnt_q, rs2_cnt_q;

  logic              inc, dec;

  // Next-state computation for every register. Reads sample these next-state
  // arrays so a same-cycle writeback/reservation/flush is forwarded.
  always_comb begin
    ovf_d  = ovf_q;
    busy_d = 1'b0;
    inc    = 1'b0;
    dec    = 1'b0;
    for (int i = 0; i < REG_CNT; i++) begin
      regs_d[i] = regs_q[i];
      wcnt_d[i] = wcnt_q[i];
      if (i == 0) begin
        // x0 is hardwired: no data, never pending, never errors.
        regs_d[i] = '0;
        wcnt_d[i] = '0;
      end else begin
        inc = write_rd_wcnt && (rd_id == LOG_REG_CNT'(i));
        dec = wb_en && (wb_id == LOG_REG_CNT'(i));
        if (inc && !dec) begin
          if (wcnt_q[i] == WCNT_MAX) begin
            ovf_d = 1'b1;
          end else begin
            wcnt_d[i] = wcnt_q[i] + 1'b1;
          end
        end else if (dec && !inc) begin
          // A writeback with nothing pending is a stale result after flush.
          if (wcnt_q[i] != '0) begin
            wcnt_d[i] = wcnt_q[i] - 1'b1;
          end
        end
        // Writeback data always lands, even when flushed or stale.
        if (dec) begin
          regs_d[i] = wb_val;
        end
        if (flush) begin
          wcnt_d[i] = '0;
        end
      end
      busy_d = busy_d | (wcnt_d[i] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_CNT; i++) begin
        regs_q[i] <= '0;
        wcnt_q[i] <= '0;
      end
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
      rs1_val_q <= '0;
      rs1_cnt_q <= '0;
      rs2_val_q <= '0;
      rs2_cnt_q <= '0;
    end else if (rdy) begin
      for (int i = 0; i < REG_CNT; i++) begin
        regs_q[i] <= regs_d[i];
        wcnt_q[i] <= wcnt_d[i];
      end
      busy_q <= busy_d;
      ovf_q  <= ovf_d;
      if (read_rs1) begin
        rs1_val_q <= regs_d[rs1_id];
        rs1_cnt_q <= wcnt_d[rs1_id];
      end
      if (read_rs2) begin
        rs2_val_q <= regs_d[rs2_id];
        rs2_cnt_q <= wcnt_d[rs2_id];
      end
    end
  end

  assign rs1_val_raw = rs1_val_q;
  assign rs1_wcnt    = 32'(rs1_cnt_q);
  assign rs2_val_raw = rs2_val_q;
  assign rs2_wcnt    = 32'(rs2_cnt_q);
  assign busy_any    = busy_q;
  assign ovf_err     = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
// ============================================================================
// Module   : tb_regfile_scoreboard
// Purpose  : Self-checking bench for regfile_scoreboard. A table of
//            one-cycle vectors with hand-computed expected outputs, plus
//            hand-written reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        read_rs1, read_rs2;
  logic [4:0]  rs1_id, rs2_id;
  logic [31:0] rs1_val_raw, rs1_wcnt, rs2_val_raw, rs2_wcnt;
  logic        write_rd_wcnt;
  logic [4:0]  rd_id;
  logic        wb_en;
  logic [4:0]  wb_id;
  logic [31:0] wb_val;
  logic        flush;
  logic        busy_any, ovf_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  regfile_scoreboard #(.REG_CNT(32), .LOG_REG_CNT(5), .WCNT_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .read_rs1(read_rs1), .rs1_id(rs1_id), .rs1_val_raw(rs1_val_raw), .rs1_wcnt(rs1_wcnt),
    .read_rs2(read_rs2), .rs2_id(rs2_id), .rs2_val_raw(rs2_val_raw), .rs2_wcnt(rs2_wcnt),
    .write_rd_wcnt(write_rd_wcnt), .rd_id(rd_id),
    .wb_en(wb_en), .wb_id(wb_id), .wb_val(wb_val),
    .flush(flush), .busy_any(busy_any), .ovf_err(ovf_err)
  );

  typedef struct {
    string       name;
    logic        rdy;
    logic        rd1;
    logic [4:0]  id1;
    logic        rd2;
    logic [4:0]  id2;
    logic        res;
    logic [4:0]  rdid;
    logic        wb;
    logic [4:0]  wbid;
    logic [31:0] wbv;
    logic        fl;
    logic [31:0] e1v;
    logic [3:0]  e1c;
    logic [31:0] e2v;
    logic [3:0]  e2c;
    logic        eb;
    logic        eo;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string name, logic rdy_v,
                              logic rd1, logic [4:0] id1, logic rd2, logic [4:0] id2,
                              logic res, logic [4:0] rdid,
                              logic wb, logic [4:0] wbid, logic [31:0] wbv, logic fl,
                              logic [31:0] e1v, logic [3:0] e1c,
                              logic [31:0] e2v, logic [3:0] e2c, logic eb, logic eo);
    vec_t v;
    v.name = name; v.rdy = rdy_v;
    v.rd1 = rd1; v.id1 = id1; v.rd2 = rd2; v.id2 = id2;
    v.res = res; v.rdid = rdid; v.wb = wb; v.wbid = wbid; v.wbv = wbv; v.fl = fl;
    v.e1v = e1v; v.e1c = e1c; v.e2v = e2v; v.e2c = e2c; v.eb = eb; v.eo = eo;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_all(string name, logic [31:0] e1v, logic [3:0] e1c,
                         logic [31:0] e2v, logic [3:0] e2c, logic eb, logic eo);
    chk({name, ".rs1_val"}, rs1_val_raw, e1v);
    chk({name, ".rs1_wcnt"}, rs1_wcnt, {28'd0, e1c});
    chk({name, ".rs2_val"}, rs2_val_raw, e2v);
    chk({name, ".rs2_wcnt"}, rs2_wcnt, {28'd0, e2c});
    chk({name, ".busy_any"}, {31'd0, busy_any}, {31'd0, eb});
    chk({name, ".ovf_err"}, {31'd0, ovf_err}, {31'd0, eo});
  endtask

  // Called at a negedge: drive, let one rising edge pass, check, return at negedge.
  task automatic apply(vec_t v);
    rdy = v.rdy;
    read_rs1 = v.rd1; rs1_id = v.id1;
    read_rs2 = v.rd2; rs2_id = v.id2;
    write_rd_wcnt = v.res; rd_id = v.rdid;
    wb_en = v.wb; wb_id = v.wbid; wb_val = v.wbv;
    flush = v.fl;
    @(posedge clk);
    #1;
    chk_all(v.name, v.e1v, v.e1c, v.e2v, v.e2c, v.eb, v.eo);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Fields: name rdy | rd1 id1 rd2 id2 | res rdid | wb wbid wbv fl |
    //         e1v e1c e2v e2c busy ovf
    tbl.push_back(mk("rst_read_x5", 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("reserve_x3", 1, 1, 3, 0, 0, 1, 3, 0, 0, 0, 0,
                     0, 1, 0, 0, 1, 0));
    tbl.push_back(mk("poll_x3", 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0,
                     0, 1, 0, 0, 1, 0));
    tbl.push_back(mk("wb_x3_fwd", 1, 1, 3, 0, 0, 0, 0, 1, 3, 32'hDEADBEEF, 0,
                     32'hDEADBEEF, 0, 0, 0, 0, 0));
    tbl.push_back(mk("reserve_x7", 1, 0, 0, 1, 7, 1, 7, 0, 0, 0, 0,
                     32'hDEADBEEF, 0, 0, 1, 1, 0));
    tbl.push_back(mk("res_wb_x7", 1, 1, 7, 0, 0, 1, 7, 1, 7, 32'h12345678, 0,
                     32'h12345678, 1, 0, 1, 1, 0));
    tbl.push_back(mk("dual_x7", 1, 1, 7, 1, 7, 0, 0, 0, 0, 0, 0,
                     32'h12345678, 1, 32'h12345678, 1, 1, 0));
    tbl.push_back(mk("retire_x7", 1, 0, 0, 1, 7, 0, 0, 1, 7, 32'h12345678, 0,
                     32'h12345678, 1, 32'h12345678, 0, 0, 0));
    tbl.push_back(mk("x0_ignored", 1, 1, 0, 1, 0, 1, 0, 1, 0, 32'd5, 0,
                     0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 15; k++)
      tbl.push_back(mk($sformatf("sat_x9_%0d", k), 1, 1, 9, 0, 0, 1, 9, 0, 0, 0, 0,
                       0, 4'(k), 0, 0, 1, 0));
    tbl.push_back(mk("sat_x9_ovf", 1, 1, 9, 0, 0, 1, 9, 0, 0, 0, 0,
                     0, 15, 0, 0, 1, 1));
    tbl.push_back(mk("flush", 1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 1,
                     0, 0, 0, 0, 0, 1));
    tbl.push_back(mk("stale_wb_x9", 1, 1, 9, 0, 0, 0, 0, 1, 9, 32'hA5, 0,
                     32'hA5, 0, 0, 0, 0, 1));
    tbl.push_back(mk("rdy0_freeze", 0, 1, 4, 1, 4, 1, 4, 1, 4, 32'h44, 0,
                     32'hA5, 0, 0, 0, 0, 1));
    tbl.push_back(mk("rdy1_apply", 1, 1, 4, 1, 4, 1, 4, 1, 4, 32'h44, 0,
                     32'h44, 0, 32'h44, 0, 0, 1));
    tbl.push_back(mk("reserve_x4_a", 1, 1, 4, 0, 0, 1, 4, 0, 0, 0, 0,
                     32'h44, 1, 32'h44, 0, 1, 1));
    tbl.push_back(mk("reserve_x4_b", 1, 1, 4, 0, 0, 1, 4, 0, 0, 0, 0,
                     32'h44, 2, 32'h44, 0, 1, 1));
    tbl.push_back(mk("rdy0_flush", 0, 1, 4, 1, 4, 1, 4, 1, 4, 32'h99, 1,
                     32'h44, 2, 32'h44, 0, 1, 1));

    rst = 1'b0; rdy = 1'b1;
    read_rs1 = 0; rs1_id = 0; read_rs2 = 0; rs2_id = 0;
    write_rd_wcnt = 0; rd_id = 0; wb_en = 0; wb_id = 0; wb_val = 0; flush = 0;
    repeat (3) @(negedge clk);
    chk_all("in_reset", 0, 0, 0, 0, 0, 0);
    rst = 1'b1;

    foreach (tbl[i]) apply(tbl[i]);

    // Asynchronous reset mid-poll of x4 (count 2): outputs clear before any edge.
    rdy = 1'b1; read_rs1 = 1'b1; rs1_id = 5'd4;
    read_rs2 = 0; write_rd_wcnt = 0; wb_en = 0; flush = 0;
    #2;
    rst = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_all("rst_held", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    apply(mk("post_rst_x4", 1, 1, 4, 1, 4, 0, 0, 0, 0, 0, 0,
             0, 0, 0, 0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
